// File: rtl/mips_shift_pkg.sv
// rtl/mips_shift_pkg.sv - shared mode constants and FSM encoding for the iterative shifter
//
// Purpose: one place for the shift-mode codes (as driven on Mode) and the
// controller state encoding, so the datapath step and the controller agree.
// Ports: none (package).

package mips_shift_pkg;

  // Shift mode codes carried on Mode and held in the captured mode register.
  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_ROTR = 2'b11;

  // Controller states. 2'b11 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Bits needed to hold a per-cycle shift amount in the range 0..step.
  function automatic int amt_width(input int step);
    return $clog2(step + 1);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift of 0..STEP bits in a selected mode
//
// Purpose: the single shift stage reused every SHIFT cycle. Small STEP keeps
// the shifter mux tree narrow; the controller iterates it to reach Shamt.
// Ports:
//   data   in   WIDTH  working value to shift
//   amt    in   AMT_W  bits to shift this cycle, 0..STEP
//   mode   in   2      SLL / SRL / SRA / ROTR code
//   result out  WIDTH  shifted value

module shift_step
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AMT_W = amt_width(STEP)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  // One extra bit so the complementary rotate amount can reach WIDTH itself.
  localparam int BACK_W = $clog2(WIDTH) + 1;

  logic [BACK_W-1:0] back_amt;

  always_comb begin
    // For amt = 0 this equals WIDTH, and a shift by WIDTH yields zero, so the
    // rotate collapses cleanly to data with no special case.
    back_amt = BACK_W'(WIDTH) - BACK_W'(amt);

    result = data;
    case (mode)
      SHIFT_SLL:  result = data << amt;
      SHIFT_SRL:  result = data >> amt;
      // The working MSB is still the captured sign bit on every step, since
      // each arithmetic step copies it back into the top positions.
      SHIFT_SRA:  result = $signed(data) >>> amt;
      SHIFT_ROTR: result = (data >> amt) | (data << back_amt);
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - multi-cycle SLL/SRL/SRA/ROTR unit with Start/Done handshake
//
// Purpose: shifts an operand by Shamt in up to STEP bits per cycle so a narrow
// shifter can replace a full barrel shifter in the EX stage.
// Ports:
//   Clk    in   1        rising-edge clock
//   Rst_n  in   1        synchronous active-low reset
//   Start  in   1        request, sampled only in IDLE
//   Mode   in   2        shift mode, captured with Start
//   In     in   WIDTH    operand, captured with Start
//   Shamt  in   SHAMT_W  shift amount, captured with Start
//   Busy   out  1        high in SHIFT and DONE
//   Done   out  1        one-cycle pulse, Out valid
//   Out    out  WIDTH    result register, held until next completion or reset

module iterative_shifter
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [1:0]         Mode,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Out
);

  localparam int AMT_W = amt_width(STEP);
  // Compare width wide enough to hold STEP, which may equal WIDTH.
  localparam int CMP_W = SHAMT_W + 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   out_q;

  logic [CMP_W-1:0]   rem_ext;
  logic [CMP_W-1:0]   k_full;
  logic [AMT_W-1:0]   step_amt;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   step_result;

  // k = min(STEP, remaining); the final step may be shorter than STEP.
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    k_full   = (rem_ext >= CMP_W'(STEP)) ? CMP_W'(STEP) : rem_ext;
    step_amt = AMT_W'(k_full);
    rem_next = rem_q - SHAMT_W'(k_full);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (work_q),
    .amt    (step_amt),
    .mode   (mode_q),
    .result (step_result)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = (Shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (rem_next == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      work_q <= '0;
      rem_q  <= '0;
      mode_q <= SHIFT_SLL;
      out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            work_q <= In;
            rem_q  <= Shamt;
            mode_q <= Mode;
            // Zero shift skips SHIFT entirely, so the result is the operand.
            if (Shamt == '0) begin
              out_q <= In;
            end
          end
        end
        SHIFT: begin
          work_q <= step_result;
          rem_q  <= rem_next;
          if (rem_next == '0) begin
            out_q <= step_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Decoded from state only, so no input reaches an output combinationally.
  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Out  = out_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// tb/tb_iterative_shifter.sv - self-checking bench for iterative_shifter with STEP=1 and STEP=4

module tb_iterative_shifter;

  logic        clk;
  logic        rst_n;

  logic        s1_start, s4_start;
  logic [1:0]  s1_mode,  s4_mode;
  logic [31:0] s1_in,    s4_in;
  logic [4:0]  s1_shamt, s4_shamt;

  logic        busy1, busy4;
  logic        done1, done4;
  logic [31:0] out1,  out4;

  int tests  = 0;
  int failed = 0;

  iterative_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Start(s1_start), .Mode(s1_mode), .In(s1_in),
    .Shamt(s1_shamt), .Busy(busy1), .Done(done1), .Out(out1)
  );

  iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Start(s4_start), .Mode(s4_mode), .In(s4_in),
    .Shamt(s4_shamt), .Busy(busy4), .Done(done4), .Out(out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit-by-bit definition of each shift mode.
  function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d, input int sh);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (m)
        2'b00:   r[i] = (i - sh >= 0) ? d[i - sh] : 1'b0;
        2'b01:   r[i] = (i + sh < 32) ? d[i + sh] : 1'b0;
        2'b10:   r[i] = (i + sh < 32) ? d[i + sh] : d[31];
        default: r[i] = d[(i + sh) % 32];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [1:0] m,
                       input logic [31:0] d, input logic [4:0] sh);
    if (sel == 1) begin
      s4_start = st; s4_mode = m; s4_in = d; s4_shamt = sh;
    end else begin
      s1_start = st; s1_mode = m; s1_in = d; s1_shamt = sh;
    end
  endtask

  task automatic sample(input int sel, output logic b, output logic dn, output logic [31:0] o);
    if (sel == 1) begin
      b = busy4; dn = done4; o = out4;
    end else begin
      b = busy1; dn = done1; o = out1;
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge of
  // cycle lat+1, when the DUT is idle again, so calls chain back-to-back.
  task automatic run_op(input int sel, input logic [1:0] m, input logic [31:0] d,
                        input logic [4:0] sh, input string name);
    int step;
    int lat;
    logic [31:0] exp_out;
    logic b, dn;
    logic [31:0] o;
    step    = (sel == 1) ? 4 : 1;
    lat     = (int'(sh) + step - 1) / step + 1;
    exp_out = ref_shift(m, d, int'(sh));
    drive(sel, 1'b1, m, d, sh);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) drive(sel, 1'b0, 2'($urandom), $urandom, 5'($urandom));
      sample(sel, b, dn, o);
      tests++;
      if (b !== (c <= lat)) begin
        failed++;
        $display("FAIL %s busy step%0d cyc%0d: got %b want %b", name, step, c, b, (c <= lat));
      end
      tests++;
      if (dn !== (c == lat)) begin
        failed++;
        $display("FAIL %s done step%0d cyc%0d: got %b want %b", name, step, c, dn, (c == lat));
      end
      if (c >= lat) begin
        tests++;
        if (o !== exp_out) begin
          failed++;
          $display("FAIL %s out step%0d cyc%0d m=%0d in=%h sh=%0d: got %h want %h",
                   name, step, c, m, d, sh, o, exp_out);
        end
      end
    end
  endtask

  task automatic check_const(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b1, 2'b00, 32'hFFFF_FFFF, 5'd3);
    drive(1, 1'b1, 2'b00, 32'hFFFF_FFFF, 5'd3);
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 2'b00, 32'h0, 5'd0);
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_const("reset busy1", {31'b0, busy1}, 32'h0);
    check_const("reset done1", {31'b0, done1}, 32'h0);
    check_const("reset out1", out1, 32'h0);
    check_const("reset busy4", {31'b0, busy4}, 32'h0);
    check_const("reset done4", {31'b0, done4}, 32'h0);
    check_const("reset out4", out4, 32'h0);
  endtask

  task automatic test_directed();
    run_op(0, 2'b00, 32'h0000_0001, 5'd2, "sll2");
    check_const("sll2 value", out1, 32'h0000_0004);
    run_op(1, 2'b10, 32'h8000_0000, 5'd31, "sra31");
    check_const("sra31 value", out4, 32'hFFFF_FFFF);
    run_op(1, 2'b01, 32'h8000_0000, 5'd31, "srl31");
    check_const("srl31 value", out4, 32'h0000_0001);
    run_op(1, 2'b11, 32'h1234_5678, 5'd8, "rotr8");
    check_const("rotr8 value", out4, 32'h7812_3456);
    for (int m = 0; m < 4; m++) begin
      run_op(0, 2'(m), 32'hDEAD_BEEF, 5'd0, "zero1");
      check_const("zero1 value", out1, 32'hDEAD_BEEF);
      run_op(1, 2'(m), 32'hDEAD_BEEF, 5'd0, "zero4");
      check_const("zero4 value", out4, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_busy_ignore();
    drive(0, 1'b1, 2'b00, 32'h0000_0001, 5'd10);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      tests++;
      if (busy1 !== (c <= 11)) begin
        failed++;
        $display("FAIL ignore busy cyc%0d: got %b want %b", c, busy1, (c <= 11));
      end
      tests++;
      if (done1 !== (c == 11)) begin
        failed++;
        $display("FAIL ignore done cyc%0d: got %b want %b", c, done1, (c == 11));
      end
      if (c == 11) check_const("ignore out", out1, 32'h0000_0400);
      // Extra requests land in SHIFT (cycle 4) and in the DONE cycle (11).
      if (c == 1 || c == 5 || c == 12) drive(0, 1'b0, 2'b00, 32'h0, 5'd0);
      if (c == 4 || c == 11) drive(0, 1'b1, 2'b00, 32'hFFFF_FFFF, 5'd1);
    end
    check_const("ignore out held", out1, 32'h0000_0400);
  endtask

  task automatic test_reset_abort();
    drive(0, 1'b1, 2'b00, 32'h0000_0F0F, 5'd20);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, 2'b00, 32'h0, 5'd0);
      if (c <= 5) begin
        tests++;
        if (busy1 !== 1'b1) begin
          failed++;
          $display("FAIL abort busy cyc%0d: got %b want 1", c, busy1);
        end
      end else begin
        tests++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
          failed++;
          $display("FAIL abort idle cyc%0d: got busy=%b done=%b want 0 0", c, busy1, done1);
        end
      end
      if (c == 6) begin
        check_const("abort out1", out1, 32'h0);
        check_const("abort out4", out4, 32'h0);
      end
      if (c == 5) rst_n = 1'b0;
      if (c == 6) rst_n = 1'b1;
    end
    run_op(0, 2'b00, 32'h0000_0003, 5'd5, "after abort");
    check_const("after abort value", out1, 32'h0000_0060);
  endtask

  task automatic test_back_to_back_random();
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 30; i++) begin
        run_op(sel, 2'($urandom), $urandom, 5'($urandom), "random");
      end
      run_op(sel, 2'b11, 32'hA5A5_0FF0, 5'd31, "rotr31");
      run_op(sel, 2'b10, 32'h7FFF_FFFF, 5'd31, "sra31pos");
      run_op(sel, 2'b00, 32'hFFFF_FFFF, 5'd31, "sll31");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
